// File: rtl/axi_pkg.sv
// Shared AXI encodings and responder state type for the instruction-fetch
// read path; imported by the responder and its address generator.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_BEAT  = 2'd3
  } state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat byte address for FIXED/INCR/WRAP bursts; shared
// between the read and write responders.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  input  logic [7:0]        i_len,
  input  logic [1:0]        i_burst,
  output logic [ADDR_W-1:0] o_next_addr
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] w_step;
  logic [ADDR_W-1:0] w_incr;
  logic [ADDR_W-1:0] w_bound;
  logic [ADDR_W-1:0] w_mask;

  assign w_step  = ONE << i_size;
  assign w_incr  = i_addr + w_step;
  assign w_bound = ({{(ADDR_W-8){1'b0}}, i_len} + ONE) << i_size;
  assign w_mask  = w_bound - ONE;

  // Reserved burst type holds the address like FIXED
  always_comb begin
    case (i_burst)
      BURST_FIXED: o_next_addr = i_addr;
      BURST_INCR:  o_next_addr = w_incr;
      BURST_WRAP:  o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
      default:     o_next_addr = i_addr;
    endcase
  end

endmodule

// File: rtl/axi_read_responder.sv
// AXI4 AR/R responder serving bursts from a 1-cycle-latency single-port SRAM,
// with optional first-beat delay and DECERR/SLVERR reporting.
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int                ADDR_W = 32,
  parameter int                DATA_W = 32,
  parameter int                ID_W   = 4,
  parameter int                MEM_AW = 16,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
  parameter int                DELAY  = 0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_arvalid,
  output logic              o_arready,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [ID_W-1:0]   i_arid,
  input  logic [7:0]        i_arlen,
  input  logic [2:0]        i_arsize,
  input  logic [1:0]        i_arburst,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic [DATA_W-1:0] o_rdata,
  output logic [1:0]        o_rresp,
  output logic              o_rlast,
  output logic [ID_W-1:0]   o_rid,
  output logic              o_mem_en,
  output logic [MEM_AW-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int              LG_BYTES  = $clog2(DATA_W / 8);
  localparam logic [2:0]      MAX_SIZE  = 3'(LG_BYTES);
  localparam logic [ADDR_W:0] MEM_TOP   = {1'b0, BASE} + ((ADDR_W+1)'(DATA_W / 8) << MEM_AW);
  localparam logic [3:0]      WAIT_INIT = 4'((DELAY > 0) ? DELAY - 1 : 0);

  function automatic logic [MEM_AW-1:0] word_addr(input logic [ADDR_W-1:0] a);
    word_addr = MEM_AW'((a - BASE) >> LG_BYTES);
  endfunction

  state_e             r_state;
  logic               r_arready;
  logic               r_rvalid;
  logic               r_rlast;
  logic [1:0]         r_rresp;
  logic [ID_W-1:0]    r_rid;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_len;
  logic [2:0]         r_size;
  logic [1:0]         r_burst;
  logic [7:0]         r_beat;
  logic [3:0]         r_wait;

  logic [ADDR_W-1:0]  w_next_addr;
  logic               w_decerr;
  logic               w_slverr;
  logic [1:0]         w_resp;
  logic               w_mem_en;
  logic [MEM_AW-1:0]  w_mem_addr;
  logic               w_sram_ok;
  logic [7:0]         w_beat_inc;

  axi_burst_addr #(
    .ADDR_W (ADDR_W)
  ) u_burst_addr (
    .i_addr      (r_addr),
    .i_size      (r_size),
    .i_len       (r_len),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  assign w_decerr = ({1'b0, i_araddr} < {1'b0, BASE}) || ({1'b0, i_araddr} >= MEM_TOP);
  assign w_slverr = (i_arsize > MAX_SIZE) || (i_arburst == BURST_RSVD) ||
                    ((i_arburst == BURST_WRAP) && !wrap_len_ok(i_arlen));
  assign w_sram_ok  = (r_rresp != RESP_DECERR);
  assign w_beat_inc = r_beat + 8'd1;

  // Response code for an incoming AR; a decode miss outranks a protocol error
  always_comb begin
    if (w_decerr) begin
      w_resp = RESP_DECERR;
    end else if (w_slverr) begin
      w_resp = RESP_SLVERR;
    end else begin
      w_resp = RESP_OKAY;
    end
  end

  // SRAM port: prefetch the next beat in the same cycle the current one is taken
  always_comb begin
    w_mem_en   = 1'b0;
    w_mem_addr = {MEM_AW{1'b0}};
    case (r_state)
      ST_ISSUE: begin
        w_mem_en   = w_sram_ok;
        w_mem_addr = word_addr(r_addr);
      end
      ST_BEAT: begin
        w_mem_en   = w_sram_ok && i_rready && !r_rlast;
        w_mem_addr = word_addr(w_next_addr);
      end
      default: begin
        w_mem_en   = 1'b0;
        w_mem_addr = {MEM_AW{1'b0}};
      end
    endcase
  end

  // Burst sequencer with registered AR/R handshake outputs
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rid     <= {ID_W{1'b0}};
      r_addr    <= {ADDR_W{1'b0}};
      r_len     <= 8'd0;
      r_size    <= 3'd0;
      r_burst   <= BURST_FIXED;
      r_beat    <= 8'd0;
      r_wait    <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_arready && i_arvalid) begin
            r_arready <= 1'b0;
            r_addr    <= i_araddr;
            r_rid     <= i_arid;
            r_len     <= i_arlen;
            r_size    <= i_arsize;
            r_burst   <= i_arburst;
            r_rresp   <= w_resp;
            r_wait    <= WAIT_INIT;
            r_state   <= (DELAY > 0) ? ST_WAIT : ST_ISSUE;
          end else begin
            r_arready <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_wait == 4'd0) begin
            r_state <= ST_ISSUE;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        ST_ISSUE: begin
          r_rvalid <= 1'b1;
          r_rlast  <= (r_len == 8'd0);
          r_beat   <= 8'd0;
          r_state  <= ST_BEAT;
        end
        ST_BEAT: begin
          if (i_rready) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_beat  <= w_beat_inc;
              r_rlast <= (w_beat_inc == r_len);
              r_addr  <= w_next_addr;
            end
          end else begin
            r_state <= ST_BEAT;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
          r_rlast   <= 1'b0;
        end
      endcase
    end
  end

  assign o_arready  = r_arready;
  assign o_rvalid   = r_rvalid;
  assign o_rlast    = r_rlast;
  assign o_rresp    = r_rresp;
  assign o_rid      = r_rid;
  assign o_rdata    = (r_rvalid && w_sram_ok) ? i_mem_rdata : {DATA_W{1'b0}};
  assign o_mem_en   = w_mem_en;
  assign o_mem_addr = w_mem_addr;

endmodule
